spi_target_port: RTL and testbench
==================================

// Module: spi_target_port
// PURPOSE
// - SPI responder (target) for the board's bit-banged SPI master (MOSI/SCK/nSS[x]/MISO[x]).
// - Oversamples SCK/MOSI/SS_N on CLK, shifts bytes MSB-first and exposes them through a 2-entry RX queue.
// - Returns TX bytes on MISO. Used as an on-board SD/flash stand-in and as a bench responder.
// PARAMETERS
// - CPOL     0     idle SCK level; CPHA fixed 0 (sample on leading edge, shift on trailing edge)
// - TX_IDLE  8'hFF byte shifted out when no TX byte is loaded (underrun)
// - SYNC     2     synchronizer depth for SCK/MOSI/SS_N (>=2)
// PORTS
// - CLK       in   1  system clock; SCK must stay below CLK/8
// - RST       in   1  synchronous reset, active high
// - SCK       in   1  SPI clock from master (asynchronous)
// - MOSI      in   1  serial data from master (asynchronous)
// - SS_N      in   1  target select, active low (asynchronous)
// - MISO      out  1  serial data to master
// - MISO_OE   out  1  MISO drive enable; 1 only while selected
// - RX_DATA   out  8  head of RX queue
// - RX_VALID  out  1  RX queue non-empty
// - RX_READY  in   1  pop RX head when RX_VALID && RX_READY
// - TX_DATA   in   8  next byte to send
// - TX_VALID  in   1  TX byte offered
// - TX_READY  out  1  TX holding register empty; accepted on TX_VALID && TX_READY
// - SEL       out  1  synchronized select (1 = transaction active)
// - OVERRUN   out  1  sticky: a byte completed while the RX queue was full
// - UNDERRUN  out  1  sticky: byte started with no TX byte loaded
// - ERR_CLR   in   1  clears OVERRUN/UNDERRUN
// BEHAVIOUR
// - Reset values: MISO=1, MISO_OE=0, RX_VALID=0, RX_DATA=0, TX_READY=1, SEL=0, OVERRUN=0, UNDERRUN=0.
//   Bit counter=0, shift regs=0, state IDLE.
// - Sync stage: inputs pass SYNC flops. Edges are detected on the last two SCK/SS_N samples.
//   Leading SCK edge = 0->1 when CPOL=0, 1->0 when CPOL=1.
// - FSM IDLE: MISO_OE=0, SEL=0. On SS_N fall -> LOAD.
// - FSM LOAD (1 cycle): tx_shift <= holding (clears TX_READY path) or TX_IDLE (UNDERRUN set).
//   MISO = tx_shift[7]. MISO_OE=1, SEL=1. -> SHIFT.
// - FSM SHIFT, on leading edge: rx_shift <= {rx_shift[6:0],MOSI_s}; bitcnt++.
// - FSM SHIFT, on trailing edge:
//   - bitcnt!=0: tx_shift <<= 1.
//   - bitcnt==0 (wrapped 7->0 at the 8th leading edge): reload tx_shift as in LOAD.
// - Byte complete at the 8th leading edge; rx_shift with the new bit pushed the same CLK.
//   If queue full, byte dropped, OVERRUN=1, queue unchanged.
// - SS_N rise in any state -> IDLE next cycle: partial byte discarded, bitcnt=0, MISO_OE=0.
//   RX queue and TX holding preserved.
// - RX queue: 2 entries. Push and pop in the same cycle on a full queue succeed (no overrun).
//   RX_DATA stable while RX_VALID && !RX_READY.
// - TX holding: 1 entry. TX_READY=0 while loaded; empties the cycle it transfers to tx_shift.
//   TX_VALID in the transfer cycle is not accepted (TX_READY=0) until next cycle.
// - Latency: MOSI bit to rx_shift = SYNC+1 CLK after the SCK edge; MISO update = SYNC+1 CLK after the trailing edge.
// - ERR_CLR coincident with a new error event: the flag stays set (set wins).
// - RST mid-transfer: all to reset values. The next transfer starts only after a fresh SS_N fall.
// STRUCTURE
// - Shared package: CPOL encoding, TX_IDLE default, FSM state enum {IDLE, LOAD, SHIFT}.
// - One sub-module: spi_port_sync (SYNC-deep synchronizer + edge detect for SCK and SS_N, plain sync for MOSI).
// - Main module holds FSM, shift regs, bit counter, RX queue, TX holding and flags.
// TESTING
// - Single byte, CPOL=0, SCK=CLK/16:
//   - TX_DATA=8'hA5 loaded, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=8'h3C, RX_VALID=1.
// - No TX loaded -> MISO shifts 8'hFF, UNDERRUN=1.
//   - ERR_CLR -> UNDERRUN=0.
// - Three bytes 01,02,03 with RX_READY=0 -> queue holds 01,02; OVERRUN=1.
//   - Pops return 01 then 02.
// - Abort: SS_N raised after 5 bits of 8'hFF -> no push; next transfer 8'h81 -> RX_DATA=8'h81.
// - Back-to-back: TX bytes 11,22 offered while selected -> 11 then 22 on MISO, no underrun.
// - Reset mid-byte, bit 4 -> MISO_OE=0, RX_VALID=0.
//   - Further SCK pulses without a new SS_N fall produce no RX.

Source files
------------

// File: rtl/spi_target_port_pkg.sv
// Shared constants for the SPI target port: clock polarity encoding, underrun fill byte
// and FSM state codes.
package spi_target_port_pkg;

  localparam logic CPOL_IDLE_LOW  = 1'b0;
  localparam logic CPOL_IDLE_HIGH = 1'b1;

  localparam logic [7:0] TX_IDLE_DEFAULT = 8'hFF;

  localparam int RX_DEPTH = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

endpackage

// File: rtl/spi_port_sync.sv
// Synchronizes the asynchronous SPI pins into clk and flags SCK/SS_N edges.
// Edges are masked until the chains hold real samples, so a select held low through reset is not seen as a fall.
module spi_port_sync #(
  parameter int   SYNC = 2,
  parameter logic CPOL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic mosi_i,
  input  logic ss_n_i,
  output logic mosi_s_o,
  output logic sck_lead_o,
  output logic sck_trail_o,
  output logic ss_fall_o,
  output logic ss_rise_o
);

  logic [SYNC-1:0] sck_q;
  logic [SYNC-1:0] mosi_q;
  logic [SYNC-1:0] ss_q;
  logic            sck_prev_q;
  logic            ss_prev_q;
  logic [SYNC:0]   valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q      <= {SYNC{CPOL}};
      mosi_q     <= '0;
      ss_q       <= '1;
      sck_prev_q <= CPOL;
      ss_prev_q  <= 1'b1;
      valid_q    <= '0;
    end else begin
      sck_q      <= {sck_q[SYNC-2:0], sck_i};
      mosi_q     <= {mosi_q[SYNC-2:0], mosi_i};
      ss_q       <= {ss_q[SYNC-2:0], ss_n_i};
      sck_prev_q <= sck_q[SYNC-1];
      ss_prev_q  <= ss_q[SYNC-1];
      valid_q    <= {valid_q[SYNC-1:0], 1'b1};
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic edges_ok;

  assign edges_ok = valid_q[SYNC];
  assign sck_rise = sck_q[SYNC-1] & ~sck_prev_q;
  assign sck_fall = ~sck_q[SYNC-1] & sck_prev_q;

  assign mosi_s_o    = mosi_q[SYNC-1];
  assign sck_lead_o  = edges_ok & ((CPOL == 1'b0) ? sck_rise : sck_fall);
  assign sck_trail_o = edges_ok & ((CPOL == 1'b0) ? sck_fall : sck_rise);
  assign ss_fall_o   = edges_ok & ~ss_q[SYNC-1] & ss_prev_q;
  assign ss_rise_o   = edges_ok & ss_q[SYNC-1] & ~ss_prev_q;

endmodule

// File: rtl/spi_target_port.sv
// SPI target (CPHA=0): shifts bytes MSB-first, 2-entry RX queue, 1-entry TX holding
// register and sticky overrun/underrun flags.
module spi_target_port
  import spi_target_port_pkg::*;
#(
  parameter logic       CPOL    = CPOL_IDLE_LOW,
  parameter logic [7:0] TX_IDLE = TX_IDLE_DEFAULT,
  parameter int         SYNC    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       SS_N,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       SEL,
  output logic       OVERRUN,
  output logic       UNDERRUN,
  input  logic       ERR_CLR
);

  logic mosi_s;
  logic sck_lead;
  logic sck_trail;
  logic ss_fall;
  logic ss_rise;

  spi_port_sync #(
    .SYNC (SYNC),
    .CPOL (CPOL)
  ) u_sync (
    .clk_i       (CLK),
    .rst_i       (RST),
    .sck_i       (SCK),
    .mosi_i      (MOSI),
    .ss_n_i      (SS_N),
    .mosi_s_o    (mosi_s),
    .sck_lead_o  (sck_lead),
    .sck_trail_o (sck_trail),
    .ss_fall_o   (ss_fall),
    .ss_rise_o   (ss_rise)
  );

  logic [1:0] state_q, state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;

  logic [7:0] rx_mem_q [RX_DEPTH];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] rx_count_q, rx_count_d;

  logic       load_req;
  logic       underrun_set;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       pop;
  logic       push_ok;
  logic       overrun_set;

  assign rx_byte = {rx_shift_q[6:0], mosi_s};

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bitcnt_d     = bitcnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    load_req     = 1'b0;
    underrun_set = 1'b0;
    byte_done    = 1'b0;

    if (TX_VALID && !hold_valid_q) begin
      hold_d       = TX_DATA;
      hold_valid_d = 1'b1;
    end

    // Deselect aborts from any state; the partial byte is thrown away.
    if (ss_rise) begin
      state_d    = ST_IDLE;
      bitcnt_d   = 3'd0;
      rx_shift_d = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          load_req = 1'b1;
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_lead) begin
            rx_shift_d = rx_byte;
            bitcnt_d   = bitcnt_q + 3'd1;
            byte_done  = (bitcnt_q == 3'd7);
          end
          if (sck_trail) begin
            if (bitcnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
            else                  load_req   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load_req) begin
      if (hold_valid_q) begin
        tx_shift_d   = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d   = TX_IDLE;
        underrun_set = 1'b1;
      end
    end
  end

  // A push into a full queue still lands when the head is popped in the same cycle.
  assign pop         = (rx_count_q != 2'd0) && RX_READY;
  assign push_ok     = byte_done && ((rx_count_q != 2'd2) || pop);
  assign overrun_set = byte_done && !push_ok;

  always_comb begin
    rx_count_d = rx_count_q;
    case ({push_ok, pop})
      2'b10:   rx_count_d = rx_count_q + 2'd1;
      2'b01:   rx_count_d = rx_count_q - 2'd1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  assign overrun_d  = overrun_set  | (overrun_q  & ~ERR_CLR);
  assign underrun_d = underrun_set | (underrun_q & ~ERR_CLR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      tx_shift_q   <= 8'h00;
      rx_shift_q   <= 8'h00;
      bitcnt_q     <= 3'd0;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rx_count_q   <= 2'd0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bitcnt_q     <= bitcnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      rx_count_q   <= rx_count_d;
      if (push_ok) begin
        rx_mem_q[wr_ptr_q] <= rx_byte;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign MISO     = (state_q == ST_IDLE) ? 1'b1 : tx_shift_q[7];
  assign MISO_OE  = (state_q != ST_IDLE);
  assign SEL      = (state_q != ST_IDLE);
  assign RX_DATA  = rx_mem_q[rd_ptr_q];
  assign RX_VALID = (rx_count_q != 2'd0);
  assign TX_READY = ~hold_valid_q;
  assign OVERRUN  = overrun_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_spi_target_port.sv
// Directed bench for spi_target_port: bit-banged CPOL=0 master at SCK = CLK/16.
module tb_spi_target_port;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic       SS_N = 1'b1;
  logic       MISO;
  logic       MISO_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       SEL;
  logic       OVERRUN;
  logic       UNDERRUN;
  logic       ERR_CLR = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_target_port #(
    .CPOL    (1'b0),
    .TX_IDLE (8'hFF),
    .SYNC    (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .SS_N     (SS_N),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .SEL      (SEL),
    .OVERRUN  (OVERRUN),
    .UNDERRUN (UNDERRUN),
    .ERR_CLR  (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tx_offer(input logic [7:0] d);
    int guard = 0;
    while (!TX_READY && guard < 200) begin
      tick(1);
      guard++;
    end
    checks++;
    if (TX_READY !== 1'b1) begin
      errors++;
      $display("FAIL tx_offer_timeout: TX_READY=%b required 1 within 200 cycles", TX_READY);
    end else begin
      TX_DATA  = d;
      TX_VALID = 1'b1;
      tick(1);
      TX_VALID = 1'b0;
    end
  endtask

  // Master clocks nbits bits of b, capturing MISO just before each leading edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit last_fall,
                          output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      tick(4);
      miso_byte = {miso_byte[6:0], MISO};
      SCK = 1'b1;
      tick(8);
      if (i != nbits - 1 || last_fall) SCK = 1'b0;
      tick(4);
    end
    $display("xfer: mosi=%h bits=%0d miso=%h", b, nbits, miso_byte);
  endtask

  task automatic select_target();
    SS_N = 1'b0;
    tick(8);
  endtask

  task automatic deselect_target();
    SCK  = 1'b0;
    SS_N = 1'b1;
    tick(8);
  endtask

  task automatic clear_errors();
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string name);
    checks++;
    if (RX_VALID !== 1'b1 || RX_DATA !== exp) begin
      errors++;
      $display("FAIL %s: RX_VALID=%b RX_DATA=%h required RX_VALID=1 RX_DATA=%h",
               name, RX_VALID, RX_DATA, exp);
    end
    RX_READY = 1'b1;
    tick(1);
    RX_READY = 1'b0;
    $display("pop: %s data=%h", name, exp);
  endtask

  task automatic test_reset();
    logic [14:0] got;
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(1);
    got = {MISO, MISO_OE, RX_VALID, RX_DATA, TX_READY, SEL, OVERRUN, UNDERRUN};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: {MISO,OE,RXV,RXD,TXR,SEL,OVR,UND}=%b required 100000000001000", got);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] m;
    tx_offer(8'hA5);
    checks++;
    if (TX_READY !== 1'b0) begin
      errors++;
      $display("FAIL tx_loaded: TX_READY=%b required 0", TX_READY);
    end
    select_target();
    checks++;
    if ({SEL, MISO_OE, TX_READY} !== 3'b111) begin
      errors++;
      $display("FAIL selected: {SEL,MISO_OE,TX_READY}=%b required 111", {SEL, MISO_OE, TX_READY});
    end
    spi_bits(8'h3C, 8, 1'b1, m);
    checks++;
    if (m !== 8'hA5) begin
      errors++;
      $display("FAIL single_miso: got %h required a5", m);
    end
    deselect_target();
    checks++;
    if ({SEL, MISO_OE, MISO} !== 3'b001) begin
      errors++;
      $display("FAIL deselected: {SEL,MISO_OE,MISO}=%b required 001", {SEL, MISO_OE, MISO});
    end
    pop_expect(8'h3C, "single_rx");
    clear_errors();
  endtask

  task automatic test_underrun();
    logic [7:0] m;
    checks++;
    if (UNDERRUN !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pre: UNDERRUN=%b required 0", UNDERRUN);
    end
    select_target();
    spi_bits(8'h00, 8, 1'b1, m);
    checks++;
    if (m !== 8'hFF || UNDERRUN !== 1'b1) begin
      errors++;
      $display("FAIL underrun_fill: miso=%h UNDERRUN=%b required ff 1", m, UNDERRUN);
    end
    deselect_target();
    pop_expect(8'h00, "underrun_rx");
    clear_errors();
    checks++;
    if (UNDERRUN !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: UNDERRUN=%b required 0", UNDERRUN);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] m;
    select_target();
    spi_bits(8'h01, 8, 1'b1, m);
    spi_bits(8'h02, 8, 1'b1, m);
    spi_bits(8'h03, 8, 1'b1, m);
    deselect_target();
    checks++;
    if (OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: OVERRUN=%b required 1", OVERRUN);
    end
    pop_expect(8'h01, "overrun_pop1");
    pop_expect(8'h02, "overrun_pop2");
    checks++;
    if (RX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL overrun_empty: RX_VALID=%b required 0", RX_VALID);
    end
    clear_errors();
    checks++;
    if (OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: OVERRUN=%b required 0", OVERRUN);
    end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    select_target();
    spi_bits(8'hFF, 5, 1'b1, m);
    deselect_target();
    checks++;
    if (RX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_push: RX_VALID=%b required 0", RX_VALID);
    end
    select_target();
    spi_bits(8'h81, 8, 1'b1, m);
    deselect_target();
    pop_expect(8'h81, "abort_next_rx");
    clear_errors();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1;
    logic [7:0] m2;
    tx_offer(8'h11);
    select_target();
    tx_offer(8'h22);
    spi_bits(8'h5A, 8, 1'b1, m1);
    spi_bits(8'hC3, 8, 1'b0, m2);
    checks++;
    if (m1 !== 8'h11 || m2 !== 8'h22) begin
      errors++;
      $display("FAIL b2b_miso: got %h %h required 11 22", m1, m2);
    end
    checks++;
    if (UNDERRUN !== 1'b0) begin
      errors++;
      $display("FAIL b2b_underrun: UNDERRUN=%b required 0", UNDERRUN);
    end
    SCK = 1'b0;
    tick(8);
    deselect_target();
    checks++;
    if (RX_VALID !== 1'b1 || RX_DATA !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_rx_head: RX_VALID=%b RX_DATA=%h required 1 5a", RX_VALID, RX_DATA);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] m;
    select_target();
    spi_bits(8'hF0, 4, 1'b1, m);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checks++;
    if ({MISO_OE, RX_VALID, SEL, MISO} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid: {MISO_OE,RX_VALID,SEL,MISO}=%b required 0001",
               {MISO_OE, RX_VALID, SEL, MISO});
    end
    spi_bits(8'hAA, 8, 1'b1, m);
    tick(8);
    checks++;
    if (RX_VALID !== 1'b0 || SEL !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_rx: RX_VALID=%b SEL=%b required 0 0", RX_VALID, SEL);
    end
    SS_N = 1'b1;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_underrun();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
